alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NREQ, default 2: number of requesters, legal range 2..4.
REQ-002 Parameter DATA_W, default 32: operand/result width; only 32 is supported.
REQ-003 Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
REQ-004 Port list, in order:
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous active-high reset.
- `req_valid` input NREQ: per-requester operation valid.
- `req_ready` output NREQ: per-requester accept, at most one bit high.
- `req_op` input 4*NREQ: opcode of requester i at bits [4i+3:4i].
- `req_a` input DATA_W*NREQ: operand A of requester i at slice i.
- `req_b` input DATA_W*NREQ: operand B of requester i at slice i.
- `rsp_valid` output 1: response valid.
- `rsp_ready` input 1: response consumer accept.
- `rsp_id` output 2: index of the requester that owns the response.
- `rsp_result` output DATA_W: ALU result.
- `rsp_zero` output 1: result equals 0.
- `rsp_gt` output 1: signed A > signed B.
- `perf_accept_cnt` output 32: count of accepted requests.
- `perf_stall_cnt` output 32: count of cycles with rsp_valid high and rsp_ready low.

Function
REQ-005 Grant: `can_issue` = !rsp_valid || rsp_ready; the winner is chosen round-robin starting at last_grant+1 mod NREQ among valid requesters.
REQ-006 `req_ready[i]` = can_issue && winner==i; it is combinational from req_valid, rsp_valid, rsp_ready and the pointer.
REQ-007 Accept: req_valid[i] && req_ready[i]; last_grant updates to i only on accept.
REQ-008 The winner's op/a/b drive a single shared alu instance combinationally. On accept, result/zero/gt/id are registered into the rsp_* outputs and rsp_valid is set the next cycle (latency 1 cycle).
REQ-009 States:
- EMPTY (rsp_valid=0): accept goes to FULL.
- FULL (rsp_valid=1): rsp_ready && accept stays FULL and loads the new response; rsp_ready && no accept goes to EMPTY; !rsp_ready holds.
REQ-010 While rsp_valid && !rsp_ready, all rsp_* outputs are held stable and req_ready is all zero.
REQ-011 Sustained throughput is one operation per cycle while rsp_ready stays high.
REQ-012 Opcodes pass through unchanged: ops other than 0..3 yield result 0, zero=1, and gt computed from the operands.
REQ-013 Arithmetic wraps modulo 2^32 with no overflow flag.
REQ-014 With a single valid requester, that requester is granted regardless of pointer position.
REQ-015 The pointer wraps from NREQ-1 to 0.
REQ-016 Protocol: a requester holds valid, op, a and b stable until accepted; behaviour is undefined if it does not.
REQ-017 No valid requesters: no accept and no state change other than the response drain.

Reset
REQ-018 On rst: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_gt=0, last_grant=NREQ-1 (so requester 0 wins first), and both perf counters=0.
REQ-019 Reset mid-operation drops any pending response, and req_ready is 0 during the reset cycle.

Configuration
REQ-020 Macro ALU_ARBITER_PERF_EN compiles the performance counters in or out.
REQ-021 With ALU_ARBITER_PERF_EN defined: perf_accept_cnt increments per accept and perf_stall_cnt per stall cycle; both saturate at 0xFFFFFFFF.
REQ-022 Without ALU_ARBITER_PERF_EN: both perf ports are tied to constant 0 and no counter flops exist; the port list is unchanged.

Structure
REQ-023 Shared package alu_pkg holds the opcode constants (ADD=0, SUB=1, AND=2, OR=3, NOP=15) and the opcode width.
REQ-024 The arbiter instantiates exactly one sub-module, alu; the round-robin picker stays inline.

Verification
REQ-025 Single request, no backpressure: req_valid=01, op=ADD, a=5, b=7 -> next cycle rsp_valid=1, id=0, result=12, zero=0, gt=0.
REQ-026 Contention: both requesters valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1 and rsp_id follows one cycle later.
REQ-027 Backpressure: rsp_ready=0 for 3 cycles after a SUB with a=3, b=3 -> result=0 and zero=1 held stable for 3 cycles, req_ready=0 throughout, perf_stall_cnt=3 when the macro is defined.
REQ-028 Signed compare: op=SUB, a=0xFFFFFFFF, b=1 -> result=0xFFFFFFFE, gt=0; op=AND, a=1, b=0xFFFFFFFF -> result=1, gt=1.
REQ-029 Reset mid-transaction: rst asserted while rsp_valid=1 and rsp_ready=0 -> next cycle rsp_valid=0 and requester 0 wins the first post-reset contention.
REQ-030 Illegal opcode: op=7, a=9, b=4 -> result=0, zero=1, gt=1; with NREQ=3, requesters 1 and 2 valid and last_grant=2 -> requester 1 is granted.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants and response state type shared by alu and alu_arbiter
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_AND = 4'd2;
  localparam logic [OP_W-1:0] OP_OR  = 4'd3;
  localparam logic [OP_W-1:0] OP_NOP = 4'd15;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU: add/sub/and/or with zero and signed greater-than flags
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              gt
);

  // Unknown opcodes (including NOP) produce 0; gt still reflects the operands.
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NOP:  result = '0;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
  assign gt   = ($signed(a) > $signed(b));

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter feeding one shared ALU into a single-entry response register
// Optional performance counters are compiled in with `define ALU_ARBITER_PERF_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [OP_W*NREQ-1:0]   req_op,
  input  logic [DATA_W*NREQ-1:0] req_a,
  input  logic [DATA_W*NREQ-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [1:0]             rsp_id,
  output logic [DATA_W-1:0]      rsp_result,
  output logic                   rsp_zero,
  output logic                   rsp_gt,
  output logic [31:0]            perf_accept_cnt,
  output logic [31:0]            perf_stall_cnt
);

  rsp_state_t        state, state_nxt;
  logic [1:0]        last_grant;
  logic [1:0]        winner;
  logic              found;
  logic              can_issue;
  logic              accept;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic              alu_zero, alu_gt;

  // Search starts one past the last granted requester and wraps at NREQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int d = 1; d <= NREQ; d++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req_valid[i] && (i == (int'(last_grant) + d) % NREQ)) begin
          winner = 2'(i);
          found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    alu_op = '0;
    alu_a  = '0;
    alu_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == 2'(i)) begin
        alu_op = req_op[i*OP_W +: OP_W];
        alu_a  = req_a[i*DATA_W +: DATA_W];
        alu_b  = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  alu #(.DATA_W(DATA_W)) u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_result),
    .zero   (alu_zero),
    .gt     (alu_gt)
  );

  assign accept = |(req_valid & req_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      last_grant <= 2'(NREQ - 1);
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_gt     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= winner;
        rsp_id     <= winner;
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
        rsp_gt     <= alu_gt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_FULL;
      ST_FULL:  if (rsp_ready && !accept) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // Grants are suppressed while the held response is stalled and during reset.
  always_comb begin
    rsp_valid = (state == ST_FULL);
    can_issue = !rsp_valid || rsp_ready;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = !rst && can_issue && found && (winner == 2'(i));
    end
  end

`ifdef ALU_ARBITER_PERF_EN
  logic [31:0] accept_cnt, stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      accept_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (accept && (accept_cnt != 32'hFFFF_FFFF)) accept_cnt <= accept_cnt + 32'd1;
      if (rsp_valid && !rsp_ready && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_accept_cnt = accept_cnt;
  assign perf_stall_cnt  = stall_cnt;
`else
  assign perf_accept_cnt = 32'd0;
  assign perf_stall_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed bench for alu_arbiter with a cycle-level reference model
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req_valid, req_ready;
  logic [7:0]  req_op;
  logic [63:0] req_a, req_b;
  logic        rsp_valid, rsp_ready, rsp_zero, rsp_gt;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_result, perf_accept_cnt, perf_stall_cnt;

  logic [2:0]  v3, ready3;
  logic [11:0] op3;
  logic [95:0] a3, b3;
  logic        valid3, zero3, gt3;
  logic [1:0]  id3;
  logic [31:0] result3, pacc3, pstall3;

  alu_arbiter #(.NREQ(2), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_gt(rsp_gt),
    .perf_accept_cnt(perf_accept_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  alu_arbiter #(.NREQ(3), .DATA_W(32)) dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_ready(ready3),
    .req_op(op3), .req_a(a3), .req_b(b3),
    .rsp_valid(valid3), .rsp_ready(1'b1), .rsp_id(id3),
    .rsp_result(result3), .rsp_zero(zero3), .rsp_gt(gt3),
    .perf_accept_cnt(pacc3), .perf_stall_cnt(pstall3)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] perf_exp(input int n);
`ifdef ALU_ARBITER_PERF_EN
    return 32'(n);
`else
    return 32'd0 & 32'(n);
`endif
  endfunction

  // Reference model of the 2-requester instance, advanced once per clock.
  logic        m_valid = 1'b0;
  logic [1:0]  m_id    = 2'd0;
  logic [31:0] m_res   = 32'd0;
  logic        m_zero  = 1'b0;
  logic        m_gt    = 1'b0;
  int          m_last  = 1;
  int          m_acc   = 0;
  int          m_stall = 0;

  always @(negedge clk) begin
    logic [1:0] e_ready;
    int w;
    e_ready = 2'b00;
    if (!rst && (!m_valid || rsp_ready)) begin
      for (int d = 1; d <= 2; d++) begin
        w = (m_last + d) % 2;
        if (((req_valid >> w) & 2'b01) != 2'b00) begin
          e_ready = 2'(1 << w);
          break;
        end
      end
    end
    chk("m_req_ready", 32'(req_ready), 32'(e_ready));
    chk("m_rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("m_rsp_id", 32'(rsp_id), 32'(m_id));
    chk("m_rsp_result", rsp_result, m_res);
    chk("m_rsp_flags", {30'd0, rsp_zero, rsp_gt}, {30'd0, m_zero, m_gt});
    chk("m_perf_accept", perf_accept_cnt, perf_exp(m_acc));
    chk("m_perf_stall", perf_stall_cnt, perf_exp(m_stall));
    if (rst) begin
      m_valid = 1'b0; m_id = 2'd0; m_res = 32'd0; m_zero = 1'b0; m_gt = 1'b0;
      m_last = 1; m_acc = 0; m_stall = 0;
    end else begin
      if (m_valid && !rsp_ready) m_stall++;
      if ((e_ready & req_valid) != 2'b00) begin
        w       = e_ready[1] ? 1 : 0;
        m_res   = ref_result(req_op[w*4 +: 4], req_a[w*32 +: 32], req_b[w*32 +: 32]);
        m_zero  = (m_res == 32'd0);
        m_gt    = $signed(req_a[w*32 +: 32]) > $signed(req_b[w*32 +: 32]);
        m_id    = 2'(w);
        m_valid = 1'b1;
        m_last  = w;
        m_acc++;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[r*4 +: 4]   = op;
    req_a[r*32 +: 32]  = a;
    req_b[r*32 +: 32]  = b;
  endtask

  task automatic drive3(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    op3[r*4 +: 4]  = op;
    a3[r*32 +: 32] = a;
    b3[r*32 +: 32] = b;
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b1; req_valid = 2'b11;
    req_op = '0; req_a = '0; req_b = '0;
    v3 = 3'b000; op3 = '0; a3 = '0; b3 = '0;
    tick(); tick();
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_result", rsp_result, 32'd0);
    chk("reset_perf", perf_accept_cnt | perf_stall_cnt, 32'd0);

    rst = 1'b0; req_valid = 2'b01; drive(0, OP_ADD, 32'd5, 32'd7);
    #1 chk("single_ready", 32'(req_ready), 32'd1);
    tick();
    chk("add_valid", 32'(rsp_valid), 32'd1);
    chk("add_id", 32'(rsp_id), 32'd0);
    chk("add_result", rsp_result, 32'd12);
    chk("add_flags", {30'd0, rsp_zero, rsp_gt}, 32'd0);

    drive(0, OP_SUB, 32'hFFFF_FFFF, 32'd1);
    tick();
    chk("sub_neg_result", rsp_result, 32'hFFFF_FFFE);
    chk("sub_neg_gt", 32'(rsp_gt), 32'd0);
    drive(0, OP_AND, 32'd1, 32'hFFFF_FFFF);
    tick();
    chk("and_result", rsp_result, 32'd1);
    chk("and_gt", 32'(rsp_gt), 32'd1);
    drive(0, 4'd7, 32'd9, 32'd4);
    tick();
    chk("illegal_op", {rsp_result[29:0], rsp_zero, rsp_gt}, 32'd3);

    drive(0, OP_ADD, 32'd1, 32'd2);
    drive(1, OP_OR, 32'hF0, 32'h0F);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("contend_id", 32'(rsp_id), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("contend_result", rsp_result, (k % 2 == 0) ? 32'hFF : 32'd3);
      chk("contend_valid", 32'(rsp_valid), 32'd1);
    end

    req_valid = 2'b01;
    #1 chk("lone_requester", 32'(req_ready), 32'd1);
    tick();
    drive(0, OP_SUB, 32'd3, 32'd3);
    tick();
    rsp_ready = 1'b0; req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_hold", {rsp_result[29:0], rsp_valid, rsp_zero}, 32'd3);
      tick();
    end
    chk("stall_count", perf_stall_cnt, perf_exp(3));
    chk("accept_count", perf_accept_cnt, perf_exp(10));

    rst = 1'b1;
    tick();
    chk("midreset_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0; rsp_ready = 1'b1;
    #1 chk("post_reset_grant", 32'(req_ready), 32'd1);
    tick();
    chk("post_reset_id0", 32'(rsp_id), 32'd0);
    tick();
    chk("post_reset_id1", 32'(rsp_id), 32'd1);
    req_valid = 2'b00;

    v3 = 3'b110; drive3(1, 4'd7, 32'd9, 32'd4); drive3(2, OP_ADD, 32'd1, 32'd1);
    #1 chk("n3_grant1", 32'(ready3), 32'b010);
    tick();
    chk("n3_id1", 32'(id3), 32'd1);
    chk("n3_illegal", {result3[29:0], zero3, gt3}, 32'd3);
    #1 chk("n3_grant2", 32'(ready3), 32'b100);
    tick();
    chk("n3_id2", {result3[29:0], id3}, {30'd2, 2'd2});
    v3 = 3'b011; drive3(0, OP_ADD, 32'd4, 32'd4);
    #1 chk("n3_wrap", 32'(ready3), 32'b001);
    tick();
    chk("n3_id0", {result3[29:0], id3}, {30'd8, 2'd0});
    v3 = 3'b000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
